// File: rtl/dmem_pkg.sv
// Shared constants and FSM state encoding for the data memory responder.
package dmem_pkg;

  localparam int WORD_W          = 16;
  localparam int DEPTH_DEF       = 256;
  localparam int WAIT_CYCLES_DEF = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage load/store bus between the datapath (master) and the data memory (slave).
interface data_mem_responder_if;
  import dmem_pkg::*;

  logic              req;
  logic              we;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic              ready;
  logic [WORD_W-1:0] rdata;
  logic              err;
  logic              stall;

  modport master (
    output req, we, addr, wdata,
    input  ready, rdata, err, stall
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rdata, err, stall
  );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 16 storage: synchronous write, registered read with a clear path for bad addresses.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Store path; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wdata;
  end

  // Load result register; holds until the next load completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= rd_clr ? '0 : mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: req/ready handshake with a fixed access latency and a
// stall output that freezes the datapath while an access is in flight.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int                AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WORD_W:0]   DEPTH_L  = (WORD_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  WAIT_CNT = CNT_W'(WAIT_CYCLES);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_range
    $error("data_mem_responder: WAIT_CYCLES must be within 0..15");
  end

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              ready_q;
  logic              err_q;

  logic              we_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;

  logic              accept;
  logic              fire;
  logic              in_range;
  logic              wr_en;
  logic              rd_en;
  logic [WORD_W-1:0] rd_data;

  // A new request is taken from IDLE, or from RESP for back-to-back service.
  assign accept   = bus.req && (state == ST_IDLE || state == ST_RESP);
  assign fire     = (state == ST_WAIT) && (cnt == '0);
  assign in_range = ({1'b0, addr_q} < DEPTH_L);
  assign wr_en    = fire && we_q && in_range;
  assign rd_en    = fire && !we_q;

  // Request latch: fields captured once at acceptance, ignored afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.we;
      addr_q  <= bus.addr;
      wdata_q <= bus.wdata;
    end
  end

  // Control FSM with wait counter and registered ready/err pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            state <= ST_WAIT;
            cnt   <= WAIT_CNT;
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state   <= ST_RESP;
            ready_q <= 1'b1;
            err_q   <= !in_range;
          end
        end
        ST_RESP: begin
          if (bus.req) begin
            state <= ST_WAIT;
            cnt   <= WAIT_CNT;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .rd_clr  (!in_range),
    .addr    (addr_q[AW-1:0]),
    .wdata   (wdata_q),
    .rd_data (rd_data)
  );

  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.rdata = rd_data;
  assign bus.stall = (state == ST_WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table plus handshake corner sequences.
module tb_data_mem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  data_mem_responder_if bus ();
  data_mem_responder_if bus0 ();

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        exp_err;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[17];
  logic [15:0] exp_b2b[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One complete access on the selected DUT; returns at the negedge where ready is seen.
  task automatic access(input bit sel0, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, output logic [15:0] rd,
                        output logic e, output int lat, output int stalls);
    @(negedge clk);
    if (sel0) begin
      bus0.req = 1'b1; bus0.we = we; bus0.addr = addr; bus0.wdata = wdata;
    end else begin
      bus.req = 1'b1; bus.we = we; bus.addr = addr; bus.wdata = wdata;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req  = 1'b0;
    bus0.req = 1'b0;
    lat    = 0;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      if (sel0 ? bus0.ready : bus.ready) break;
      if (sel0 ? bus0.stall : bus.stall) stalls++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rd = sel0 ? bus0.rdata : bus.rdata;
    e  = sel0 ? bus0.err : bus.err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [15:0] rd;
    logic        e;
    int          lat;
    int          stalls;
    int          seen;
    int          t_prev;
    int          stall_cnt;
    int          bad;
    bit          got;

    reset = 1'b1;
    bus.req  = 1'b0; bus.we  = 1'b0; bus.addr  = '0; bus.wdata  = '0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;

    vecs[0]  = '{1'b1, 16'd5,     16'hBEEF, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 16'd5,     16'h0000, 1'b0, 16'hBEEF};
    vecs[2]  = '{1'b1, 16'd0,     16'h0A0A, 1'b0, 16'hBEEF};
    vecs[3]  = '{1'b1, 16'h0100,  16'h1234, 1'b1, 16'hBEEF};
    vecs[4]  = '{1'b0, 16'h0100,  16'h0000, 1'b1, 16'h0000};
    vecs[5]  = '{1'b0, 16'd0,     16'h0000, 1'b0, 16'h0A0A};
    vecs[6]  = '{1'b1, 16'd1,     16'h0011, 1'b0, 16'h0A0A};
    vecs[7]  = '{1'b1, 16'd2,     16'h0022, 1'b0, 16'h0A0A};
    vecs[8]  = '{1'b1, 16'd3,     16'h0033, 1'b0, 16'h0A0A};
    vecs[9]  = '{1'b1, 16'd7,     16'h0077, 1'b0, 16'h0A0A};
    vecs[10] = '{1'b1, 16'd8,     16'h0088, 1'b0, 16'h0A0A};
    vecs[11] = '{1'b1, 16'd9,     16'h0909, 1'b0, 16'h0A0A};
    vecs[12] = '{1'b1, 16'd255,   16'hCAFE, 1'b0, 16'h0A0A};
    vecs[13] = '{1'b0, 16'd255,   16'h0000, 1'b0, 16'hCAFE};
    vecs[14] = '{1'b1, 16'd6,     16'h0066, 1'b0, 16'hCAFE};
    vecs[15] = '{1'b1, 16'hFFFF,  16'h5555, 1'b1, 16'hCAFE};
    vecs[16] = '{1'b0, 16'hFFFF,  16'h0000, 1'b1, 16'h0000};
    exp_b2b[0] = 16'h0011;
    exp_b2b[1] = 16'h0022;
    exp_b2b[2] = 16'h0033;

    // Reset state
    #2;
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_err",   32'(bus.err),   32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'h0);
    chk("rst_stall0", 32'(bus0.stall), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Vector table
    for (int v = 0; v < 17; v++) begin
      access(1'b0, vecs[v].we, vecs[v].addr, vecs[v].wdata, rd, e, lat, stalls);
      chk($sformatf("vec%0d_latency", v), 32'(lat), 32'd3);
      chk($sformatf("vec%0d_stalls", v), 32'(stalls), 32'd3);
      chk($sformatf("vec%0d_err", v), 32'(e), 32'(vecs[v].exp_err));
      chk($sformatf("vec%0d_rdata", v), 32'(rd), 32'(vecs[v].exp_rdata));
    end

    // Back-to-back loads of addr 1,2,3 with req held high
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'd1;
    @(posedge clk);
    seen = 0; t_prev = 0; stall_cnt = 0; bad = 0;
    for (int k = 0; k < 40 && seen < 3; k++) begin
      @(negedge clk);
      if (bus.stall == bus.ready) bad++;
      if (bus.ready) begin
        chk($sformatf("b2b_rdata%0d", seen), 32'(bus.rdata), 32'(exp_b2b[seen]));
        if (seen > 0) chk($sformatf("b2b_gap%0d", seen), 32'(k - t_prev), 32'd4);
        t_prev = k;
        seen++;
        if (seen < 3) bus.addr = 16'(seen + 1);
        else bus.req = 1'b0;
      end else if (bus.stall) begin
        stall_cnt++;
      end
      @(posedge clk);
    end
    bus.req = 1'b0;
    chk("b2b_count", 32'(seen), 32'd3);
    chk("b2b_stall_cycles", 32'(stall_cnt), 32'd9);
    chk("b2b_stall_vs_ready", 32'(bad), 32'd0);

    // Input churn during WAIT
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'd7;
    @(posedge clk);
    @(negedge clk);
    bus.addr = 16'd8; bus.we = 1'b1; bus.wdata = 16'hFFFF;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.req = 1'b0;
    chk("churn_ready", 32'(got), 32'd1);
    chk("churn_rdata", 32'(bus.rdata), 32'h0077);
    access(1'b0, 1'b0, 16'd8, 16'h0000, rd, e, lat, stalls);
    chk("churn_addr8_intact", 32'(rd), 32'h0088);

    // Reset during WAIT abandons the pending store
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'd9; bus.wdata = 16'hDEAD;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    chk("midrst_stall_before", 32'(bus.stall), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_ready", 32'(bus.ready), 32'd0);
    chk("midrst_stall", 32'(bus.stall), 32'd0);
    chk("midrst_rdata", 32'(bus.rdata), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    access(1'b0, 1'b0, 16'd9, 16'h0000, rd, e, lat, stalls);
    chk("midrst_load9", 32'(rd), 32'h0909);
    chk("midrst_load9_latency", 32'(lat), 32'd3);

    // Reset during RESP keeps the completed store
    access(1'b0, 1'b1, 16'd6, 16'h6666, rd, e, lat, stalls);
    chk("resprst_ready_before", 32'(bus.ready), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("resprst_ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    access(1'b0, 1'b0, 16'd6, 16'h0000, rd, e, lat, stalls);
    chk("resprst_load6", 32'(rd), 32'h6666);

    // Zero-wait build
    access(1'b1, 1'b1, 16'd4, 16'h4444, rd, e, lat, stalls);
    chk("w0_store_latency", 32'(lat), 32'd1);
    chk("w0_store_stalls", 32'(stalls), 32'd1);
    access(1'b1, 1'b0, 16'd4, 16'h0000, rd, e, lat, stalls);
    chk("w0_load_latency", 32'(lat), 32'd1);
    chk("w0_load_stalls", 32'(stalls), 32'd1);
    chk("w0_load_rdata", 32'(rd), 32'h4444);
    chk("w0_load_err", 32'(e), 32'd0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
